btn_input_ctrl: RTL and testbench

// - Input-side peripheral for the board push-buttons: the reader counterpart of the LED/seven-segment output path.
// - Per button: synchronise the raw pin, debounce it, and detect press/release edges.
// - Latches edges into sticky pending registers.
// - Exposes state, pending and interrupt-enable registers to the core over a single-cycle register bus.
// - Raises a level interrupt while any enabled event is pending.

---
 rtl/btn_input_ctrl.sv | 150 +++++++++++++++
 tb/tb_btn_input_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_input_ctrl.sv
// btn_input_ctrl: push-button sync, debounce, edge latch, register block.
// Ports: clk, rst_n, btn_pins -> req/we/addr/wdata bus -> rdata/ack, irq.
// Option: BTN_INPUT_RELEASE_EVT_EN builds RELEASE_PEND and IRQ_EN bit1.
// Map: 0 STATE(RO) 1 PRESS_PEND(W1C) 2 RELEASE_PEND(W1C) 3 IRQ_EN(RW).
module btn_input_ctrl #(
  parameter int BTN_COUNT       = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BTN_COUNT-1:0] btn_pins,
  input  logic                 req,
  input  logic                 we,
  input  logic [1:0]           addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 ack,
  output logic                 irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BTN_COUNT-1:0] IDLE =
    BTN_ACTIVE_LOW ? {BTN_COUNT{1'b1}} : {BTN_COUNT{1'b0}};

  logic [BTN_COUNT-1:0] meta;
  logic [BTN_COUNT-1:0] sync_raw;
  logic [BTN_COUNT-1:0] sync;
  logic [BTN_COUNT-1:0] stable;
  logic [BTN_COUNT-1:0] accept;
  logic [BTN_COUNT-1:0] press_evt;
  logic [CW-1:0]        cnt [BTN_COUNT];

  logic [BTN_COUNT-1:0] press_pend;
  logic [BTN_COUNT-1:0] rel_pend;
  logic [BTN_COUNT-1:0] w1c_press;
  logic                 irq_en_press;
  logic                 irq_en_rel;
  logic                 accepted;
  logic                 wr;
  logic [31:0]          rd_val;
  logic                 unused_bits;

  assign unused_bits = ^wdata;

  // Flops reset to the released pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= IDLE;
      sync_raw <= IDLE;
    end else begin
      meta     <= btn_pins;
      sync_raw <= meta;
    end
  end

  assign sync = BTN_ACTIVE_LOW ? ~sync_raw : sync_raw;

  always_comb begin
    accept = '0;
    for (int i = 0; i < BTN_COUNT; i++) begin
      accept[i] = (sync[i] != stable[i]) && (cnt[i] == CNT_MAX);
    end
  end

  assign press_evt = accept & sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < BTN_COUNT; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable <= stable ^ accept;
      for (int i = 0; i < BTN_COUNT; i++) begin
        if (sync[i] == stable[i] || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign accepted  = req & ~ack;
  assign wr        = accepted & we;
  assign w1c_press = (wr && addr == 2'd1) ? wdata[BTN_COUNT-1:0] : '0;

  // Edge set is OR-ed after the clear so a same-cycle event wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_pend   <= '0;
      irq_en_press <= 1'b0;
    end else begin
      press_pend <= (press_pend & ~w1c_press) | press_evt;
      if (wr && addr == 2'd3) begin
        irq_en_press <= wdata[0];
      end
    end
  end

`ifdef BTN_INPUT_RELEASE_EVT_EN
  logic [BTN_COUNT-1:0] release_evt;
  logic [BTN_COUNT-1:0] w1c_rel;

  assign release_evt = accept & ~sync;
  assign w1c_rel = (wr && addr == 2'd2) ? wdata[BTN_COUNT-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_pend   <= '0;
      irq_en_rel <= 1'b0;
    end else begin
      rel_pend <= (rel_pend & ~w1c_rel) | release_evt;
      if (wr && addr == 2'd3) begin
        irq_en_rel <= wdata[1];
      end
    end
  end
`else
  assign rel_pend   = '0;
  assign irq_en_rel = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    unique case (addr)
      2'd0: rd_val[BTN_COUNT-1:0] = stable;
      2'd1: rd_val[BTN_COUNT-1:0] = press_pend;
      2'd2: rd_val[BTN_COUNT-1:0] = rel_pend;
      2'd3: rd_val[1:0] = {irq_en_rel, irq_en_press};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack   <= 1'b0;
      rdata <= '0;
      irq   <= 1'b0;
    end else begin
      ack   <= accepted;
      rdata <= (accepted && !we) ? rd_val : '0;
      irq   <= (|press_pend & irq_en_press) |
               (|rel_pend & irq_en_rel);
    end
  end

endmodule

// File: tb/tb_btn_input_ctrl.sv
// tb_btn_input_ctrl: directed + random checks of btn_input_ctrl
// against a windowed behavioural model (DEBOUNCE_CYCLES=4).
module tb_btn_input_ctrl;

`ifdef BTN_INPUT_RELEASE_EVT_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  localparam int N = 5;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [N-1:0] btn_pins;
  logic        req;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        irq;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  btn_input_ctrl #(
    .BTN_COUNT(N),
    .DEBOUNCE_CYCLES(D),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_pins(btn_pins),
    .req(req),
    .we(we),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .ack(ack),
    .irq(irq)
  );

  // Model: pressed-level history, newest first. A level is accepted
  // once the D synchronised samples (2 edges old and older) all differ.
  logic [N-1:0] hist [0:D+1];
  logic [N-1:0] m_stable, m_pp, m_rp;
  logic [1:0]   m_en;
  logic         m_ack, m_irq;
  logic [31:0]  m_rdata;

  task automatic model_reset();
    for (int k = 0; k <= D + 1; k++) hist[k] = '0;
    m_stable = '0;
    m_pp = '0;
    m_rp = '0;
    m_en = '0;
    m_ack = 1'b0;
    m_irq = 1'b0;
    m_rdata = '0;
  endtask

  task automatic model_edge();
    logic acc;
    logic [N-1:0] flip, clr;
    logic [31:0] rv;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = ~btn_pins;
    flip = '1;
    for (int k = 2; k <= D + 1; k++) flip &= hist[k] ^ m_stable;
    acc = req && !m_ack;
    case (addr)
      2'd0: rv = 32'(m_stable);
      2'd1: rv = 32'(m_pp);
      2'd2: rv = 32'(m_rp);
      default: rv = 32'(m_en);
    endcase
    clr = (acc && we) ? wdata[N-1:0] : '0;
    m_irq = ((|m_pp) && m_en[0]) || ((|m_rp) && m_en[1]);
    m_rdata = (acc && !we) ? rv : 32'd0;
    m_ack = acc;
    m_pp = (m_pp & ~((addr == 2'd1) ? clr : '0)) | (flip & ~m_stable);
    if (REL)
      m_rp = (m_rp & ~((addr == 2'd2) ? clr : '0)) | (flip & m_stable);
    if (acc && we && addr == 2'd3) m_en = wdata[1:0] & {REL, 1'b1};
    m_stable = m_stable ^ flip;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("ack", 32'(ack), 32'(m_ack));
    chk("rdata", rdata, m_rdata);
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic bus(input logic w, input logic [1:0] a,
                     input logic [31:0] d, output logic [31:0] q);
    req = 1'b1;
    we = w;
    addr = a;
    wdata = d;
    step();
    chk("bus_ack", 32'(ack), 32'd1);
    q = rdata;
    req = 1'b0;
    we = 1'b0;
    step();
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] q);
    bus(1'b0, a, 32'd0, q);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus(1'b1, a, d, q);
  endtask

  logic [31:0] q;
  int acks, wide, hold [N];
  logic prev;

  initial begin
    rst_n = 1'b0;
    btn_pins = '1;
    req = 1'b0;
    we = 1'b0;
    addr = 2'd0;
    wdata = '0;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    rd(2'd0, q); chk("state_rst", q, 32'h0);
    rd(2'd1, q); chk("press_rst", q, 32'h0);
    rd(2'd3, q); chk("en_rst", q, 32'h0);

    btn_pins[0] = 1'b0;
    repeat (3) step();
    btn_pins[0] = 1'b1;
    repeat (8) step();
    rd(2'd0, q); chk("glitch_state", q, 32'h0);
    rd(2'd1, q); chk("glitch_press", q, 32'h0);

    btn_pins[2] = 1'b0;
    repeat (5) step();
    rd(2'd0, q); chk("press_early", q, 32'h0);
    rd(2'd1, q); chk("press_pend", q, 32'h04);
    rd(2'd0, q); chk("press_state", q, 32'h04);
    wr(2'd1, 32'h04);
    rd(2'd1, q); chk("press_w1c", q, 32'h0);

    wr(2'd3, 32'h1);
    btn_pins[1] = 1'b0;
    repeat (10) step();
    chk("irq_set", 32'(irq), 32'd1);
    req = 1'b1; we = 1'b1; addr = 2'd1; wdata = 32'h02;
    step();
    chk("irq_ack_cycle", 32'(irq), 32'd1);
    req = 1'b0; we = 1'b0;
    step();
    chk("irq_fall", 32'(irq), 32'd0);
    rd(2'd1, q); chk("irq_w1c", q, 32'h0);

    btn_pins[3] = 1'b0;
    repeat (5) step();
    req = 1'b1; we = 1'b1; addr = 2'd1; wdata = 32'h08;
    step();
    req = 1'b0; we = 1'b0;
    step();
    rd(2'd1, q); chk("collide", q, 32'h08);
    wr(2'd1, 32'h08);
    rd(2'd1, q); chk("collide_clr", q, 32'h0);

    wr(2'd3, 32'h2);
    btn_pins[2] = 1'b1;
    repeat (10) step();
    rd(2'd2, q); chk("rel_pend", q, REL ? 32'h04 : 32'h0);
    chk("rel_irq", 32'(irq), REL ? 32'd1 : 32'd0);
    rd(2'd3, q); chk("rel_en", q, REL ? 32'h2 : 32'h0);

    req = 1'b1; we = 1'b0; addr = 2'd0;
    acks = 0; wide = 0; prev = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (ack) acks++;
      if (ack && prev) wide++;
      prev = ack;
    end
    req = 1'b0;
    step();
    chk("burst_acks", 32'(acks), 32'd3);
    chk("burst_wide", 32'(wide), 32'd0);

    for (int b = 0; b < N; b++) hold[b] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++) begin
        if (hold[b] == 0) begin
          btn_pins[b] = 1'($urandom_range(0, 1));
          hold[b] = $urandom_range(1, 9);
        end else begin
          hold[b]--;
        end
      end
      req = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      addr = 2'($urandom_range(0, 3));
      wdata = $urandom;
      step();
    end
    req = 1'b0;
    we = 1'b0;
    btn_pins = '1;
    repeat (10) step();

    wr(2'd1, 32'h1f);
    wr(2'd2, 32'h1f);
    wr(2'd3, 32'h1);
    btn_pins[4] = 1'b0;
    repeat (10) step();
    chk("irq_pre_rst", 32'(irq), 32'd1);
    req = 1'b1; we = 1'b0; addr = 2'd1;
    @(posedge clk);
    model_edge();
    #2;
    chk("ack_pre_rst", 32'(ack), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    model_reset();
    req = 1'b0;
    btn_pins = '1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step();
    rd(2'd0, q); chk("post_rst_state", q, 32'h0);
    rd(2'd3, q); chk("post_rst_en", q, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
